collision_scheduler: RTL and testbench

Time-multiplexes a single `aabb_collision` comparator across all on-screen objects once per frame. It sits between the sprite attribute table and game logic.
- Triggered by a frame strobe (typically start of vblank).
- Walks every unordered object pair (i<j) by reading the table through one indexed read port.
- Publishes a per-object "hit" mask that holds stable until the next scan completes.

---
 rtl/collision_scheduler_pkg.sv | 43 ++++
 rtl/aabb_collision.sv | 32 +++
 rtl/collision_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_collision_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// collision_scheduler_pkg
// Shared definitions for the collision scheduler slice:
//   - `POSITION_WIDTH : coordinate width of the sprite attribute table
//                       (a default is supplied if the build does not set it)
//   - state_e         : scheduler FSM encoding (IDLE / LOAD_A / SCAN / DONE)
//   - box_t           : one axis-aligned bounding box
//   - axis_overlap()  : strict 1-D interval overlap helper
// Optional feature macro used by the slice: COLLISION_PAIR_EVENT_EN
// (adds pair_valid / pair_a / pair_b outputs to collision_scheduler).
// -----------------------------------------------------------------------------
`ifndef POSITION_WIDTH
`define POSITION_WIDTH 10
`endif

package collision_scheduler_pkg;

    localparam int POS_W = `POSITION_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_A = 2'd1,
        ST_SCAN   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic [POS_W-1:0] x1;
        logic [POS_W-1:0] y1;
        logic [POS_W-1:0] x2;
        logic [POS_W-1:0] y2;
    } box_t;

    // Strict overlap on one axis: both spans must be non-empty (lo < hi) and
    // they must share interior points, so touching edges never count.
    function automatic logic axis_overlap(input logic [POS_W-1:0] a_lo,
                                          input logic [POS_W-1:0] a_hi,
                                          input logic [POS_W-1:0] b_lo,
                                          input logic [POS_W-1:0] b_hi);
        return (a_lo < a_hi) && (b_lo < b_hi) && (a_lo < b_hi) && (b_lo < a_hi);
    endfunction

endpackage

// File: rtl/aabb_collision.sv
// -----------------------------------------------------------------------------
// aabb_collision
// Combinational axis-aligned bounding box comparator. Reports overlap only
// when the two boxes share interior area; touching edges, zero-width or
// inverted (x2<x1 / y2<y1) boxes never overlap. Coordinates are unsigned.
// Ports:
//   a_x1_i..a_y2_i : bounds of box A
//   b_x1_i..b_y2_i : bounds of box B
//   overlap_o      : 1 when A and B overlap
// -----------------------------------------------------------------------------
`ifndef POSITION_WIDTH
`define POSITION_WIDTH 10
`endif

module aabb_collision
    import collision_scheduler_pkg::*;
(
    input  logic [`POSITION_WIDTH-1:0] a_x1_i,
    input  logic [`POSITION_WIDTH-1:0] a_y1_i,
    input  logic [`POSITION_WIDTH-1:0] a_x2_i,
    input  logic [`POSITION_WIDTH-1:0] a_y2_i,
    input  logic [`POSITION_WIDTH-1:0] b_x1_i,
    input  logic [`POSITION_WIDTH-1:0] b_y1_i,
    input  logic [`POSITION_WIDTH-1:0] b_x2_i,
    input  logic [`POSITION_WIDTH-1:0] b_y2_i,
    output logic                       overlap_o
);

    assign overlap_o = axis_overlap(a_x1_i, a_x2_i, b_x1_i, b_x2_i) &&
                       axis_overlap(a_y1_i, a_y2_i, b_y1_i, b_y2_i);

endmodule

// File: rtl/collision_scheduler.sv
// -----------------------------------------------------------------------------
// collision_scheduler
// Time-multiplexes one aabb_collision comparator over every unordered object
// pair (i<j) once per start strobe, reading the attribute table through a
// single indexed read port, and publishes a per-object hit mask that holds
// until the next scan completes.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : scan request, honoured only in IDLE
//   obj_enable         : per-slot enable, snapshotted when start is accepted
//   obj_rd_idx         : table read index (0 in IDLE, i in LOAD_A, j in SCAN)
//   obj_rd_x1..y2      : bounds of slot obj_rd_idx, same-cycle combinational
//   busy               : high from the cycle after acceptance through DONE
//   done               : one-cycle pulse in DONE
//   hit_mask           : per-object result of the last completed scan
// Optional (macro COLLISION_PAIR_EVENT_EN):
//   pair_valid, pair_a, pair_b : one event per overlapping enabled pair,
//                                one cycle after its SCAN cycle
// -----------------------------------------------------------------------------
`ifndef POSITION_WIDTH
`define POSITION_WIDTH 10
`endif

module collision_scheduler
    import collision_scheduler_pkg::*;
#(
    parameter int NUM_OBJECTS = 8,
    parameter int IDX_W       = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [NUM_OBJECTS-1:0]     obj_enable,
    output logic [IDX_W-1:0]           obj_rd_idx,
    input  logic [`POSITION_WIDTH-1:0] obj_rd_x1,
    input  logic [`POSITION_WIDTH-1:0] obj_rd_y1,
    input  logic [`POSITION_WIDTH-1:0] obj_rd_x2,
    input  logic [`POSITION_WIDTH-1:0] obj_rd_y2,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_OBJECTS-1:0]     hit_mask
`ifdef COLLISION_PAIR_EVENT_EN
    ,
    output logic                       pair_valid,
    output logic [IDX_W-1:0]           pair_a,
    output logic [IDX_W-1:0]           pair_b
`endif
);

    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_OBJECTS - 1);
    localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(NUM_OBJECTS - 2);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       i_q, i_d, j_q, j_d, rd_idx_q, rd_idx_d;
    box_t                   a_q, a_d, rd_box_s;
    logic [NUM_OBJECTS-1:0] acc_q, acc_d, en_snap_q, en_snap_d, hit_mask_q, hit_mask_d;
    logic                   busy_q, busy_d, done_q, done_d;
    logic                   overlap_s, hit_gated_s;

    assign rd_box_s = '{x1: obj_rd_x1, y1: obj_rd_y1, x2: obj_rd_x2, y2: obj_rd_y2};

    aabb_collision u_cmp (
        .a_x1_i    (a_q.x1),
        .a_y1_i    (a_q.y1),
        .a_x2_i    (a_q.x2),
        .a_y2_i    (a_q.y2),
        .b_x1_i    (obj_rd_x1),
        .b_y1_i    (obj_rd_y1),
        .b_x2_i    (obj_rd_x2),
        .b_y2_i    (obj_rd_y2),
        .overlap_o (overlap_s)
    );

    // Only pairs where both objects were enabled at acceptance may score.
    assign hit_gated_s = (state_q == ST_SCAN) && overlap_s && en_snap_q[i_q] && en_snap_q[j_q];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: the row of pair (i, last) ends each LOAD_A/SCAN pass.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD_A;
                else       state_d = ST_IDLE;
            end
            ST_LOAD_A: state_d = ST_SCAN;
            ST_SCAN: begin
                if (j_q == LAST_IDX) begin
                    if (i_q == PENULT_IDX) state_d = ST_DONE;
                    else                   state_d = ST_LOAD_A;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values; outputs are derived from the next
    // state so that they come straight out of flops aligned with state_q.
    always_comb begin
        i_d        = i_q;
        j_d        = j_q;
        a_d        = a_q;
        acc_d      = acc_q;
        en_snap_d  = en_snap_q;
        hit_mask_d = hit_mask_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    en_snap_d = obj_enable;
                    acc_d     = '0;
                    i_d       = '0;
                end else begin
                    en_snap_d = en_snap_q;
                end
            end
            ST_LOAD_A: begin
                a_d = rd_box_s;
                j_d = i_q + IDX_ONE;
            end
            ST_SCAN: begin
                if (hit_gated_s) begin
                    acc_d[i_q] = 1'b1;
                    acc_d[j_q] = 1'b1;
                end else begin
                    acc_d = acc_q;
                end
                if (j_q == LAST_IDX) begin
                    if (i_q != PENULT_IDX) i_d = i_q + IDX_ONE;
                    else                   i_d = i_q;
                end else begin
                    j_d = j_q + IDX_ONE;
                end
            end
            ST_DONE: hit_mask_d = acc_q;
            default: hit_mask_d = hit_mask_q;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        case (state_d)
            ST_LOAD_A: rd_idx_d = i_d;
            ST_SCAN:   rd_idx_d = j_d;
            default:   rd_idx_d = '0;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q        <= '0;
            j_q        <= '0;
            a_q        <= '0;
            acc_q      <= '0;
            en_snap_q  <= '0;
            hit_mask_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_idx_q   <= '0;
        end else begin
            i_q        <= i_d;
            j_q        <= j_d;
            a_q        <= a_d;
            acc_q      <= acc_d;
            en_snap_q  <= en_snap_d;
            hit_mask_q <= hit_mask_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_idx_q   <= rd_idx_d;
        end
    end

    assign obj_rd_idx = rd_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign hit_mask   = hit_mask_q;

`ifdef COLLISION_PAIR_EVENT_EN
    logic             pair_valid_q;
    logic [IDX_W-1:0] pair_a_q, pair_b_q;

    // Pair event register: one event per scoring SCAN cycle, in scan order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_valid_q <= 1'b0;
            pair_a_q     <= '0;
            pair_b_q     <= '0;
        end else begin
            pair_valid_q <= hit_gated_s;
            if (hit_gated_s) begin
                pair_a_q <= i_q;
                pair_b_q <= j_q;
            end else begin
                pair_a_q <= pair_a_q;
                pair_b_q <= pair_b_q;
            end
        end
    end

    assign pair_valid = pair_valid_q;
    assign pair_a     = pair_a_q;
    assign pair_b     = pair_b_q;
`endif

endmodule

// File: tb/tb_collision_scheduler.sv
// -----------------------------------------------------------------------------
// tb_collision_scheduler
// Self-checking bench for collision_scheduler (N=8). A table of obj3 layouts
// against a fixed obj0, hand sequences for mid-scan events, and randomized
// layouts checked against a pair-by-pair reference model.
// -----------------------------------------------------------------------------
`ifndef POSITION_WIDTH
`define POSITION_WIDTH 10
`endif

module tb_collision_scheduler;

    localparam int N = 8;

    typedef logic [5:0] pair_t;
    typedef struct {
        int         x1, y1, x2, y2;
        logic [7:0] en;
        logic [7:0] exp;
    } vec_t;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       start = 1'b0;
    logic [N-1:0]               obj_enable = '0;
    logic [2:0]                 obj_rd_idx;
    logic [`POSITION_WIDTH-1:0] obj_rd_x1, obj_rd_y1, obj_rd_x2, obj_rd_y2;
    logic                       busy, done;
    logic [N-1:0]               hit_mask;
`ifdef COLLISION_PAIR_EVENT_EN
    logic                       pair_valid;
    logic [2:0]                 pair_a, pair_b;
`endif

    logic [`POSITION_WIDTH-1:0] tx1[N], ty1[N], tx2[N], ty2[N];
    pair_t exp_pairs[$];
    pair_t got_pairs[$];
    int checks = 0;
    int errors = 0;

    assign obj_rd_x1 = tx1[obj_rd_idx];
    assign obj_rd_y1 = ty1[obj_rd_idx];
    assign obj_rd_x2 = tx2[obj_rd_idx];
    assign obj_rd_y2 = ty2[obj_rd_idx];

    collision_scheduler #(.NUM_OBJECTS(8), .IDX_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .obj_enable (obj_enable),
        .obj_rd_idx (obj_rd_idx),
        .obj_rd_x1  (obj_rd_x1),
        .obj_rd_y1  (obj_rd_y1),
        .obj_rd_x2  (obj_rd_x2),
        .obj_rd_y2  (obj_rd_y2),
        .busy       (busy),
        .done       (done),
        .hit_mask   (hit_mask)
`ifdef COLLISION_PAIR_EVENT_EN
        ,
        .pair_valid (pair_valid),
        .pair_a     (pair_a),
        .pair_b     (pair_b)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_box(input int k, input int x1, input int y1, input int x2, input int y2);
        tx1[k] = `POSITION_WIDTH'(x1);
        ty1[k] = `POSITION_WIDTH'(y1);
        tx2[k] = `POSITION_WIDTH'(x2);
        ty2[k] = `POSITION_WIDTH'(y2);
    endtask

    // obj0 at (10,10,20,20); every other object parked far away on its own.
    task automatic set_base();
        for (int k = 0; k < N; k++) set_box(k, 100 * k, 500, 100 * k + 20, 520);
        set_box(0, 10, 10, 20, 20);
    endtask

    // Two boxes overlap iff the intersection of their spans is non-empty on
    // both axes (strict: a shared edge gives an empty intersection).
    function automatic bit spans_meet(input int lo1, input int hi1, input int lo2, input int hi2);
        int lo, hi;
        lo = (lo1 > lo2) ? lo1 : lo2;
        hi = (hi1 < hi2) ? hi1 : hi2;
        return lo < hi;
    endfunction

    task automatic model_scan(input logic [7:0] en, output logic [7:0] mask);
        mask = '0;
        exp_pairs.delete();
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                if (en[i] && en[j] &&
                    spans_meet(int'(tx1[i]), int'(tx2[i]), int'(tx1[j]), int'(tx2[j])) &&
                    spans_meet(int'(ty1[i]), int'(ty2[i]), int'(ty1[j]), int'(ty2[j]))) begin
                    mask[i] = 1'b1;
                    mask[j] = 1'b1;
                    exp_pairs.push_back(pair_t'({3'(i), 3'(j)}));
                end
            end
        end
    endtask

    // Runs one scan from IDLE (called at a negedge). mid_cyc: busy cycle at
    // which obj_enable switches to en_mid and, optionally, start is pulsed.
    task automatic do_scan(input string tag, input logic [7:0] en, input logic [7:0] exp_hit,
                           input int mid_cyc, input logic [7:0] en_mid,
                           input bit start_mid, input bit start_in_done);
        int nb, nd, dpos;
        logic [7:0] mdl;
        nb = 0; nd = 0; dpos = -1;
        model_scan(en, mdl);
        got_pairs.delete();
        obj_enable = en;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100 && busy; c++) begin
            nb++;
`ifdef COLLISION_PAIR_EVENT_EN
            if (pair_valid) got_pairs.push_back({pair_a, pair_b});
`endif
            if (done) begin
                nd++;
                dpos = nb;
                if (start_in_done) start = 1'b1;
            end
            if (nb == mid_cyc) begin
                obj_enable = en_mid;
                if (start_mid) start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
        end
        chk({tag, ".busy_cycles"}, nb, 36);
        chk({tag, ".done_pulses"}, nd, 1);
        chk({tag, ".done_pos"}, dpos, 36);
        chk({tag, ".hit_mask"}, hit_mask, exp_hit);
`ifdef COLLISION_PAIR_EVENT_EN
        chk({tag, ".pair_count"}, got_pairs.size(), exp_pairs.size());
        for (int k = 0; k < got_pairs.size() && k < exp_pairs.size(); k++)
            chk({tag, ".pair"}, got_pairs[k], exp_pairs[k]);
`endif
    endtask

    vec_t tbl[8];

    initial begin
        logic [7:0] m, en_r;

        tbl[0] = '{x1: 15, y1: 15, x2: 25, y2: 25, en: 8'hFF, exp: 8'h09};
        tbl[1] = '{x1: 20, y1: 10, x2: 30, y2: 20, en: 8'hFF, exp: 8'h00};
        tbl[2] = '{x1: 15, y1: 15, x2: 25, y2: 25, en: 8'hF7, exp: 8'h00};
        tbl[3] = '{x1: 19, y1: 19, x2: 25, y2: 25, en: 8'hFF, exp: 8'h09};
        tbl[4] = '{x1: 15, y1: 12, x2: 15, y2: 18, en: 8'hFF, exp: 8'h00};
        tbl[5] = '{x1: 25, y1: 15, x2: 15, y2: 25, en: 8'hFF, exp: 8'h00};
        tbl[6] = '{x1: 10, y1: 20, x2: 20, y2: 30, en: 8'hFF, exp: 8'h00};
        tbl[7] = '{x1:  0, y1:  0, x2: 11, y2: 11, en: 8'hFE, exp: 8'h00};

        set_base();
        repeat (2) @(negedge clk);
        chk("reset.busy", busy, 1'b0);
        chk("reset.done", done, 1'b0);
        chk("reset.hit_mask", hit_mask, 8'h00);
        chk("reset.rd_idx", obj_rd_idx, 3'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle.busy", busy, 1'b0);

        for (int v = 0; v < 8; v++) begin
            set_base();
            set_box(3, tbl[v].x1, tbl[v].y1, tbl[v].x2, tbl[v].y2);
            do_scan($sformatf("vec%0d", v), tbl[v].en, tbl[v].exp, 0, 8'h00, 1'b0, 1'b0);
        end

        // Enable change mid-scan is ignored; the following scan sees it.
        set_base();
        set_box(3, 15, 15, 25, 25);
        do_scan("en_mid", 8'hF7, 8'h00, 5, 8'hFF, 1'b0, 1'b0);
        do_scan("en_next", 8'hFF, 8'h09, 0, 8'h00, 1'b0, 1'b0);

        // Start at busy cycle 5 and in the DONE cycle is dropped, not queued.
        do_scan("start_busy", 8'hFF, 8'h09, 5, 8'hFF, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("start_busy.not_queued", busy, 1'b0);

        // Three mutually overlapping objects.
        set_base();
        set_box(1, 12, 12, 22, 22);
        set_box(3, 15, 15, 25, 25);
        do_scan("triple", 8'hFF, 8'h0B, 0, 8'h00, 1'b0, 1'b0);
`ifdef COLLISION_PAIR_EVENT_EN
        chk("triple.pair_n", got_pairs.size(), 3);
        if (got_pairs.size() == 3) begin
            chk("triple.p0", got_pairs[0], 6'o01);
            chk("triple.p1", got_pairs[1], 6'o03);
            chk("triple.p2", got_pairs[2], 6'o13);
        end
`endif

        // Reset in the middle of SCAN.
        set_base();
        set_box(3, 15, 15, 25, 25);
        do_scan("pre_rst", 8'hFF, 8'h09, 0, 8'h00, 1'b0, 1'b0);
        obj_enable = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_rst.busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst.hit_mask", hit_mask, 8'h00);
        chk("mid_rst.busy", busy, 1'b0);
        chk("mid_rst.done", done, 1'b0);
        chk("mid_rst.rd_idx", obj_rd_idx, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst.idle_busy", busy, 1'b0);
        chk("post_rst.hit_mask", hit_mask, 8'h00);

        // Randomized layouts against the reference model.
        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < N; k++)
                set_box(k, $urandom_range(0, 60), $urandom_range(0, 60),
                        $urandom_range(0, 90), $urandom_range(0, 90));
            en_r = 8'($urandom);
            model_scan(en_r, m);
            do_scan($sformatf("rand%0d", r), en_r, m, 0, 8'h00, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
